// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode/funct encodings, flag indices and overflow helpers for alu
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  // I-type / top-level opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  // Signed overflow from operand and result sign bits only
  function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sd);
    return (sa != sb) && (sd != sa);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// alu_core : combinational decode, operand select and compute for alu
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] instruction,
  input  logic [31:0] reg_A,
  input  logic [31:0] reg_B,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] se_imm;
  logic [31:0] ze_imm;
  logic [31:0] sum_rr;
  logic [31:0] diff_rr;
  logic [31:0] sum_ri;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign shamt  = instruction[10:6];

  // Register field value 0 binds reg_A; anything else binds reg_B
  assign rs_val = (instruction[25:21] == 5'd0) ? reg_A : reg_B;
  assign rt_val = (instruction[20:16] == 5'd0) ? reg_A : reg_B;

  assign se_imm = {{16{instruction[15]}}, instruction[15:0]};
  assign ze_imm = {16'h0000, instruction[15:0]};

  assign sum_rr  = rs_val + rt_val;
  assign diff_rr = rs_val - rt_val;
  assign sum_ri  = rs_val + se_imm;

  always_comb begin
    result = 32'h0;
    flags  = 3'b000;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            result          = sum_rr;
            flags[FLAG_OVF] = add_ovf(rs_val[31], rt_val[31], sum_rr[31]);
          end
          FN_ADDU: result = sum_rr;
          FN_SUB: begin
            result          = diff_rr;
            flags[FLAG_OVF] = sub_ovf(rs_val[31], rt_val[31], diff_rr[31]);
          end
          FN_SUBU: result = diff_rr;
          FN_AND:  result = rs_val & rt_val;
          FN_OR:   result = rs_val | rt_val;
          FN_XOR:  result = rs_val ^ rt_val;
          FN_NOR:  result = ~(rs_val | rt_val);
          FN_SLT: begin
            result          = {31'h0, $signed(rs_val) < $signed(rt_val)};
            flags[FLAG_NEG] = result[0];
          end
          FN_SLTU: begin
            result          = {31'h0, rs_val < rt_val};
            flags[FLAG_NEG] = result[0];
          end
          FN_SLL:  result = rt_val << shamt;
          FN_SRL:  result = rt_val >> shamt;
          FN_SRA:  result = $signed(rt_val) >>> shamt;
          FN_SLLV: result = rt_val << rs_val[4:0];
          FN_SRLV: result = rt_val >> rs_val[4:0];
          FN_SRAV: result = $signed(rt_val) >>> rs_val[4:0];
          default: ;
        endcase
      end
      OP_ADDI: begin
        result          = sum_ri;
        flags[FLAG_OVF] = add_ovf(rs_val[31], se_imm[31], sum_ri[31]);
      end
      OP_ADDIU: result = sum_ri;
      OP_SLTI: begin
        result          = {31'h0, $signed(rs_val) < $signed(se_imm)};
        flags[FLAG_NEG] = result[0];
      end
      OP_SLTIU: begin
        result          = {31'h0, rs_val < se_imm};
        flags[FLAG_NEG] = result[0];
      end
      OP_ANDI: result = rs_val & ze_imm;
      OP_ORI:  result = rs_val | ze_imm;
      OP_XORI: result = rs_val ^ ze_imm;
      OP_BEQ, OP_BNE: begin
        result           = diff_rr;
        flags[FLAG_ZERO] = (rs_val == rt_val);
      end
      OP_LW, OP_SW: result = sum_ri;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// alu : registered MIPS-subset execute-stage ALU (1-cycle latency)
// Rev 1.0
// ============================================================================
`default_nettype none

module alu
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instruction,
  input  logic [31:0]        reg_A,
  input  logic [31:0]        reg_B,
  output logic signed [31:0] result,
  output logic [2:0]         flags
);

  logic [31:0] core_result;
  logic [2:0]  core_flags;

  alu_core u_core (
    .instruction (instruction),
    .reg_A       (reg_A),
    .reg_B       (reg_B),
    .result      (core_result),
    .flags       (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= 3'b000;
    end else begin
      result <= $signed(core_result);
      flags  <= core_flags;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// tb_alu : directed self-checking bench for alu with hand-computed vectors
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu;

  logic               clk;
  logic               rst_n;
  logic [31:0]        instruction;
  logic [31:0]        reg_A;
  logic [31:0]        reg_B;
  logic signed [31:0] result;
  logic [2:0]         flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .reg_A       (reg_A),
    .reg_B       (reg_B),
    .result      (result),
    .flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] shamt, input logic [5:0] funct);
    return {6'h00, rs, rt, 5'd3, shamt, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_r, input logic [2:0] exp_f);
    n_checks++;
    assert (result === exp_r) else begin
      n_fail++;
      $error("FAIL %s result: got %h expected %h", tag, result, exp_r);
    end
    n_checks++;
    assert (flags === exp_f) else begin
      n_fail++;
      $error("FAIL %s flags: got %b expected %b", tag, flags, exp_f);
    end
  endtask

  // Drive at negedge, capture at posedge, sample 1 time unit later
  task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_r, input logic [2:0] exp_f);
    @(negedge clk);
    instruction = ins;
    reg_A       = a;
    reg_B       = b;
    @(posedge clk);
    #1;
    check(tag, exp_r, exp_f);
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = 32'h0;
    reg_A       = 32'h0;
    reg_B       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_idle", 32'h0, 3'b000);

    // Non-zero inputs during reset must not reach the outputs
    instruction = r_type(5'd1, 5'd0, 5'd0, 6'h20);
    reg_A = 32'd4861;
    reg_B = 32'd5874;
    @(posedge clk);
    #1;
    check("reset_hold", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("add_first", 32'h000029EF, 3'b000);

    step("add_ovf",  r_type(5'd1, 5'd0, 5'd0, 6'h20), 32'h80000000, 32'h80000000, 32'h0, 3'b001);
    step("addu_wrap", r_type(5'd1, 5'd0, 5'd0, 6'h21), 32'h80000000, 32'h80000000, 32'h0, 3'b000);
    step("sub",      r_type(5'd0, 5'd1, 5'd0, 6'h22), 32'd0, 32'd20, 32'hFFFFFFEC, 3'b000);
    step("sub_ovf",  r_type(5'd0, 5'd1, 5'd0, 6'h22), 32'h80000000, 32'd1, 32'h7FFFFFFF, 3'b001);
    step("slt",      r_type(5'd1, 5'd0, 5'd0, 6'h2A), 32'd2, 32'd1, 32'd1, 3'b010);
    step("sltu",     r_type(5'd1, 5'd0, 5'd0, 6'h2B), 32'd2, 32'hFFFFFFFF, 32'd0, 3'b000);
    step("slti",     i_type(6'h0A, 5'd0, 5'd0, 16'hFFFA), 32'd1, 32'd0, 32'd0, 3'b000);
    step("slti_neg", i_type(6'h0A, 5'd0, 5'd0, 16'hFFFA), 32'hFFFFFFF0, 32'd0, 32'd1, 3'b010);
    step("sltiu",    i_type(6'h0B, 5'd1, 5'd0, 16'd4), 32'd0, 32'hFFFFFFFA, 32'd0, 3'b000);
    step("sltiu_se", i_type(6'h0B, 5'd1, 5'd0, 16'hFFFF), 32'd0, 32'hFFFFFFFA, 32'd1, 3'b010);
    step("addi_ovf", i_type(6'h08, 5'd0, 5'd0, 16'h0001), 32'h7FFFFFFF, 32'd0, 32'h80000000, 3'b001);
    step("sll",      r_type(5'd0, 5'd1, 5'd4, 6'h00), 32'd0, 32'hCCCCCCCC, 32'hCCCCCCC0, 3'b000);
    step("srl",      r_type(5'd0, 5'd0, 5'd4, 6'h02), 32'hCCCCCCCC, 32'd0, 32'h0CCCCCCC, 3'b000);
    step("sra",      r_type(5'd0, 5'd0, 5'd4, 6'h03), 32'hCCCCCCCC, 32'd0, 32'hFCCCCCCC, 3'b000);
    step("srav",     r_type(5'd1, 5'd0, 5'd0, 6'h07), 32'hCCCCCCCC, 32'd4, 32'hFCCCCCCC, 3'b000);
    step("sllv_5b",  r_type(5'd1, 5'd0, 5'd0, 6'h04), 32'h00000001, 32'h00000024, 32'h00000010, 3'b000);
    step("ori",      i_type(6'h0D, 5'd0, 5'd0, 16'hFFFA), 32'h14, 32'd0, 32'h0000FFFE, 3'b000);
    step("andi_ze",  i_type(6'h0C, 5'd0, 5'd0, 16'h8F0F), 32'hFFFFFFFF, 32'd0, 32'h00008F0F, 3'b000);
    step("nor",      r_type(5'd0, 5'd1, 5'd0, 6'h27), 32'hFFFFFFF1, 32'hFFFFFFF2, 32'h0000000C, 3'b000);
    step("xori",     i_type(6'h0E, 5'd1, 5'd0, 16'd12), 32'd0, 32'd9, 32'h00000005, 3'b000);
    step("beq_eq",   i_type(6'h04, 5'd1, 5'd2, 16'h0010), 32'd1, 32'd1, 32'h0, 3'b100);
    step("bne_ne",   i_type(6'h05, 5'd1, 5'd0, 16'h0010), 32'd3, 32'd7, 32'd4, 3'b000);
    step("lw",       i_type(6'h23, 5'd1, 5'd2, 16'h0000), 32'd0, 32'h810, 32'h00000810, 3'b000);
    step("sw",       i_type(6'h2B, 5'd0, 5'd2, 16'h0008), 32'd0, 32'd5, 32'h00000008, 3'b000);
    step("bad_op",   i_type(6'h3F, 5'd1, 5'd1, 16'hFFFF), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 3'b000);
    step("bad_fn",   r_type(5'd1, 5'd1, 5'd0, 6'h01), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 3'b000);

    // Load a nonzero result, then reset asynchronously between edges
    step("pre_rst",  r_type(5'd1, 5'd0, 5'd0, 6'h20), 32'd4861, 32'd5874, 32'h000029EF, 3'b000);
    instruction = r_type(5'd1, 5'd0, 5'd0, 6'h20);
    reg_A = 32'h80000000;
    reg_B = 32'h80000000;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'h0, 3'b000);
    @(posedge clk);
    #1;
    check("rst_discard", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", 32'h0, 3'b001);

    // Input changes between edges must not disturb the held output
    @(negedge clk);
    reg_A = 32'd7;
    reg_B = 32'd9;
    #2;
    check("between_edges", 32'h0, 3'b001);
    @(posedge clk);
    #1;
    check("next_edge", 32'd16, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu.md
# alu

Registered 32-bit MIPS-subset ALU for the pipelined CPU's execute stage. It decodes the raw 32-bit instruction, selects operands from two input registers, and computes the arithmetic, logic, shift, compare, branch-compare or address result. It also produces zero/negative/overflow flags. Both outputs are registered on the clock.

## Interface
- No parameters.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instruction  input  32  raw MIPS instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0]
- reg_A  input  32  operand bound to register field value 0
- reg_B  input  32  operand bound to any nonzero register field value
- result  output  32 (signed)  registered ALU result
- flags  output  3  registered flags: [2]=zero, [1]=negative, [0]=overflow

## Operation
- Operand select:
  - RS = (rs==0) ? reg_A : reg_B.
  - RT = (rt==0) ? reg_A : reg_B.
- Immediates:
  - SE = sign-extended imm.
  - ZE = zero-extended imm.
- R-type (opcode 0x00), by funct:
  - add 0x20: RS+RT; overflow flag set on signed overflow.
  - addu 0x21: RS+RT.
  - sub 0x22: RS−RT; overflow flag set on signed overflow.
  - subu 0x23: RS−RT.
  - and 0x24, or 0x25, xor 0x26, nor 0x27: bitwise on RS and RT.
  - slt 0x2A: result 1/0 for signed RS<RT; negative flag = result.
  - sltu 0x2B: same as slt, unsigned compare.
  - sll 0x00, srl 0x02, sra 0x03: shift RT by shamt.
  - sllv 0x04, srlv 0x06, srav 0x07: shift RT by RS[4:0].
- I-type, by opcode:
  - addi 0x08: RS+SE; overflow flag set on signed overflow.
  - addiu 0x09: RS+SE.
  - slti 0x0A: signed RS<SE; result 1/0, negative flag = result.
  - sltiu 0x0B: unsigned RS<SE (SE is still sign-extended); result 1/0, negative flag = result.
  - andi 0x0C, ori 0x0D, xori 0x0E: bitwise with ZE.
  - beq 0x04, bne 0x05: result RS−RT; zero flag = (RS==RT).
  - lw 0x23, sw 0x2B: result RS+SE (byte address).
- Flag rules:
  - Flags not listed for an operation are 0.
  - Zero is set only by beq/bne.
  - Overflow is set only by add/sub/addi.
  - On overflow, result holds the wrapped 32-bit value.
- Unsupported opcode or funct: result 0, flags 000.
- All arithmetic is 32-bit modular. Shift amounts use 5 bits only.

## Timing
- Combinational decode/compute; result and flags are captured on the rising edge of clk. Latency is 1 cycle: inputs stable before edge N appear on outputs after edge N.
- rst_n low: result=0 and flags=000 immediately, held while low. The first capture is at the first rising edge after deassertion.
- Reset asserted mid-stream discards the in-flight computation.
- No handshake. A new instruction is accepted every cycle; back-to-back changes yield back-to-back results.
- Inputs changing between edges have no effect on the outputs until the next edge.

## Structure
- Shared package `alu_pkg`:
  - opcode and funct localparams.
  - flag bit indices FLAG_ZERO=2, FLAG_NEG=1, FLAG_OVF=0.
- One sub-module `alu_core`: purely combinational decode, operand select and compute.
- The top `alu` wraps `alu_core` with the output register and async reset.

## Test plan
- Reset: assert rst_n=0 mid-operation → result=0x00000000, flags=000 without a clock edge.
- add, rs=1 rt=0:
  - reg_A=4861, reg_B=5874 → result 0x000029EF, flags 000, one cycle later.
  - Then reg_A=reg_B=0x80000000 → result 0, flags 001.
- sub 0−20:
  - → 0xFFFFFFEC, flags 000.
  - slt rs=1 rt=0 with reg_A=2, reg_B=1 → result 1, flags 010.
  - slti rs=0 imm=−6, reg_A=1 → result 0, flags 000.
  - sltiu rs=1 imm=4, reg_B=0xFFFFFFFA → result 0.
- Shifts on 0xCCCCCCCC:
  - sll rt=1 shamt=4 → 0xCCCCCCC0.
  - srl rt=0 shamt=4 → 0x0CCCCCCC.
  - sra rt=0 shamt=4 → 0xFCCCCCCC.
  - srav rt=0 rs=1 with reg_B=4 → 0xFCCCCCCC.
- Logic and immediates:
  - ori rs=0 imm=0xFFFA, reg_A=0x14 → 0x0000FFFE.
  - nor of 0xFFFFFFF1 and 0xFFFFFFF2 → 0x0000000C.
  - xori rs=1 imm=12, reg_B=9 → 0x5.
- Branch and memory:
  - beq with reg_A=reg_B=1 → result 0, flags 100.
  - lw rs=1 imm=0, reg_B=0x810 → 0x00000810.
  - sw rs=0 imm=8, reg_A=0 → 0x00000008.
  - Undefined opcode 0x3F → result 0, flags 000.
